// File: rtl/ads124x_pkg.sv
// Shared types and constants for the ADS124x scan sequencer.
package ads124x_pkg;

   typedef enum logic [3:0] {
      ST_IDLE, ST_SELECT, ST_WREG, ST_WREG_WAIT, ST_START,
      ST_WAIT_DRDY, ST_RDATA, ST_RDATA_WAIT, ST_OUTPUT
   } state_t;

   localparam logic [3:0] CMD_WREG_HI = 4'h4;
   localparam logic [7:0] CMD_RDATA   = 8'h12;
   localparam logic [7:0] NOP         = 8'hFF;

   localparam int TD_SLOT_LSB = 28;
   localparam int TD_TMO_BIT  = 27;
   localparam int TD_PPS_BIT  = 26;
   localparam int TD_DATA_LSB = 0;

   function automatic logic [31:0] pack_sample(input logic [3:0] slot, input logic tmo,
                                               input logic pps, input logic [23:0] data);
      logic [31:0] w;
      w = '0;
      w[TD_SLOT_LSB +: 4]  = slot;
      w[TD_TMO_BIT]        = tmo;
      w[TD_PPS_BIT]        = pps;
      w[TD_DATA_LSB +: 24] = data;
      return w;
   endfunction

endpackage

// File: rtl/ads124x_scan_sequencer_if.sv
// SPI transaction request/response and AXI4-Stream sample output of the sequencer.
interface ads124x_scan_sequencer_if;
   logic        spi_req_valid;
   logic        spi_req_ready;
   logic [31:0] spi_tx_data;
   logic [2:0]  spi_tx_len;
   logic        spi_done;
   logic [23:0] spi_rx_data;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;

   modport master (
      output spi_req_valid, spi_tx_data, spi_tx_len, m_axis_tdata, m_axis_tvalid,
      input  spi_req_ready, spi_done, spi_rx_data, m_axis_tready
   );

   modport slave (
      input  spi_req_valid, spi_tx_data, spi_tx_len, m_axis_tdata, m_axis_tvalid,
      output spi_req_ready, spi_done, spi_rx_data, m_axis_tready
   );
endinterface

// File: rtl/ads124x_sync_edge.sv
// Two-flop synchronizer plus a third stage for edge detection; FALL selects
// whether the pulse marks a high->low or low->high transition.
module ads124x_sync_edge #(
   parameter logic RST_VAL = 1'b0,
   parameter logic FALL    = 1'b0
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic d,
   output logic pulse
);
   logic [2:0] sr;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) sr <= {3{RST_VAL}};
      else          sr <= {sr[1:0], d};
   end

   assign pulse = FALL ? (sr[2] & ~sr[1]) : (~sr[2] & sr[1]);
endmodule

// File: rtl/ads124x_scan_sequencer.sv
// Autonomous ADS124x channel scan: MUX0 write, single-shot START, DRDY wait,
// RDATA readback, tagged sample out on AXI4-Stream. PPS realigns to slot 0.
module ads124x_scan_sequencer
   import ads124x_pkg::*;
#(
   parameter int         N_CH        = 8,
   parameter int         START_PULSE = 4,
   parameter int         TIMEOUT     = 2_000_000,
   parameter logic [3:0] MUX0_ADDR   = 4'h0
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  cfg_run,
   input  logic [N_CH-1:0]       cfg_chan_mask,
   input  logic [8*N_CH-1:0]     cfg_mux,
   input  logic                  pps,
   ads124x_scan_sequencer_if.master bus,
   output logic                  START,
   input  logic                  DRDY,
   output logic                  busy,
   output logic [15:0]           timeout_cnt
);
   localparam int PTRW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int PW   = (START_PULSE > 1) ? $clog2(START_PULSE) : 1;
   localparam logic [PTRW-1:0] LAST = PTRW'(N_CH - 1);

   state_t          state;
   logic [PTRW-1:0] ptr, slot;
   logic [TW-1:0]   tcnt;
   logic [PW-1:0]   pcnt;
   logic            pps_pend, pps_flag;
   logic            drdy_fall, pps_rise;

   ads124x_sync_edge #(.RST_VAL(1'b1), .FALL(1'b1)) u_drdy_sync (
      .aclk(aclk), .aresetn(aresetn), .d(DRDY), .pulse(drdy_fall));
   ads124x_sync_edge #(.RST_VAL(1'b0), .FALL(1'b0)) u_pps_sync (
      .aclk(aclk), .aresetn(aresetn), .d(pps), .pulse(pps_rise));

   assign busy = (state != ST_IDLE);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state             <= ST_IDLE;
         ptr               <= '0;
         slot              <= '0;
         tcnt              <= '0;
         pcnt              <= '0;
         pps_pend          <= 1'b0;
         pps_flag          <= 1'b0;
         START             <= 1'b0;
         timeout_cnt       <= '0;
         bus.spi_req_valid <= 1'b0;
         bus.spi_tx_data   <= '0;
         bus.spi_tx_len    <= '0;
         bus.m_axis_tvalid <= 1'b0;
         bus.m_axis_tdata  <= '0;
      end else begin
         case (state)
            ST_IDLE:
               if (cfg_run && (cfg_chan_mask != '0)) state <= ST_SELECT;
            ST_SELECT:
               if (!cfg_run || (cfg_chan_mask == '0)) begin
                  state <= ST_IDLE;
               end else if (pps_pend) begin
                  ptr      <= '0;
                  pps_pend <= 1'b0;
                  pps_flag <= 1'b1;
               end else if (cfg_chan_mask[ptr]) begin
                  slot              <= ptr;
                  bus.spi_tx_data   <= {CMD_WREG_HI, MUX0_ADDR, 8'h00, cfg_mux[{ptr, 3'b000} +: 8], 8'h00};
                  bus.spi_tx_len    <= 3'd3;
                  bus.spi_req_valid <= 1'b1;
                  state             <= ST_WREG;
               end else begin
                  ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
               end
            ST_WREG:
               if (bus.spi_req_ready) begin
                  bus.spi_req_valid <= 1'b0;
                  state             <= ST_WREG_WAIT;
               end
            ST_WREG_WAIT:
               if (bus.spi_done) begin
                  START <= 1'b1;
                  pcnt  <= '0;
                  state <= ST_START;
               end
            ST_START:
               if (pcnt == PW'(START_PULSE - 1)) begin
                  START <= 1'b0;
                  tcnt  <= '0;
                  state <= ST_WAIT_DRDY;
               end else begin
                  pcnt <= pcnt + 1'b1;
               end
            ST_WAIT_DRDY:
               if (drdy_fall) begin
                  bus.spi_tx_data   <= {CMD_RDATA, {3{NOP}}};
                  bus.spi_tx_len    <= 3'd4;
                  bus.spi_req_valid <= 1'b1;
                  state             <= ST_RDATA;
               end else if (tcnt == TW'(TIMEOUT - 1)) begin
                  if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 16'd1;
                  bus.m_axis_tdata  <= pack_sample(4'(slot), 1'b1, pps_flag, 24'h0);
                  bus.m_axis_tvalid <= 1'b1;
                  state             <= ST_OUTPUT;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            ST_RDATA:
               if (bus.spi_req_ready) begin
                  bus.spi_req_valid <= 1'b0;
                  state             <= ST_RDATA_WAIT;
               end
            ST_RDATA_WAIT:
               if (bus.spi_done) begin
                  bus.m_axis_tdata  <= pack_sample(4'(slot), 1'b0, pps_flag, bus.spi_rx_data);
                  bus.m_axis_tvalid <= 1'b1;
                  state             <= ST_OUTPUT;
               end
            ST_OUTPUT:
               if (bus.m_axis_tready) begin
                  bus.m_axis_tvalid <= 1'b0;
                  ptr               <= (slot == LAST) ? '0 : slot + 1'b1;
                  pps_flag          <= 1'b0;
                  state             <= ST_SELECT;
               end
            default: state <= ST_IDLE;
         endcase
         // A fresh PPS edge wins over the clear in SELECT so it is never lost.
         if (pps_rise) pps_pend <= 1'b1;
      end
   end
endmodule

// File: tb/tb_ads124x_scan_sequencer.sv
// Directed bench: SPI engine and ADC behavioural models, stream monitor, one task per scenario.
`timescale 1ns/1ps
module tb_ads124x_scan_sequencer;
   localparam int N_CH = 4;

   logic              aclk = 1'b0;
   logic              aresetn = 1'b0;
   logic              cfg_run = 1'b0;
   logic              pps = 1'b0;
   logic [N_CH-1:0]   cfg_chan_mask = 4'b0101;
   logic [8*N_CH-1:0] cfg_mux = 32'h67452301;
   logic              START, DRDY, busy;
   logic [15:0]       timeout_cnt;

   int errors = 0;
   int checks = 0;

   logic [31:0] words[$];
   logic [34:0] spi_log[$];

   ads124x_scan_sequencer_if bus();

   ads124x_scan_sequencer #(.N_CH(N_CH), .START_PULSE(4), .TIMEOUT(100), .MUX0_ADDR(4'h0)) dut (
      .aclk(aclk), .aresetn(aresetn), .cfg_run(cfg_run), .cfg_chan_mask(cfg_chan_mask),
      .cfg_mux(cfg_mux), .pps(pps), .bus(bus), .START(START), .DRDY(DRDY),
      .busy(busy), .timeout_cnt(timeout_cnt));

   always #5 aclk = ~aclk;

   // SPI byte engine: ready one cycle after valid, done four cycles after acceptance.
   logic       eng, cur_is_rd, blk_en;
   logic [2:0] scnt;
   logic [7:0] cur_mux, blk_mux;
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         bus.spi_req_ready <= 1'b0;
         bus.spi_done      <= 1'b0;
         eng <= 1'b0; scnt <= '0; cur_is_rd <= 1'b0; cur_mux <= '0;
      end else begin
         bus.spi_done <= 1'b0;
         if (!eng) begin
            if (bus.spi_req_valid && bus.spi_req_ready) begin
               bus.spi_req_ready <= 1'b0;
               eng  <= 1'b1;
               scnt <= '0;
               spi_log.push_back({bus.spi_tx_len, bus.spi_tx_data});
               cur_is_rd <= (bus.spi_tx_data[31:24] == 8'h12);
               if (bus.spi_tx_data[31:24] != 8'h12) cur_mux <= bus.spi_tx_data[15:8];
            end else begin
               bus.spi_req_ready <= bus.spi_req_valid;
            end
         end else begin
            scnt <= scnt + 3'd1;
            if (scnt == 3'd3) begin
               bus.spi_done <= 1'b1;
               eng <= 1'b0;
            end
         end
      end
   end

   // ADC: DRDY falls ~10 cycles after START ends unless the blocked mux code is selected.
   logic start_d, arm;
   int   dcnt;
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         DRDY <= 1'b1; start_d <= 1'b0; arm <= 1'b0; dcnt <= 0;
      end else begin
         start_d <= START;
         if (start_d && !START && !(blk_en && cur_mux == blk_mux)) begin
            arm <= 1'b1; dcnt <= 0;
         end else if (arm) begin
            dcnt <= dcnt + 1;
            if (dcnt == 10) begin DRDY <= 1'b0; arm <= 1'b0; end
         end
         if (bus.spi_done && cur_is_rd) DRDY <= 1'b1;
      end
   end

   always @(posedge aclk)
      if (aresetn && bus.m_axis_tvalid && bus.m_axis_tready) words.push_back(bus.m_axis_tdata);

   task automatic get_word(output logic [31:0] w, output bit ok);
      ok = 1'b0; w = '0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge aclk);
         if (words.size() > 0) begin w = words.pop_front(); ok = 1'b1; break; end
      end
   endtask

   task automatic wait_busy_low();
      for (int i = 0; i < 3000 && busy !== 1'b0; i++) @(negedge aclk);
   endtask

   task automatic wait_start_pulse(output bit ok);
      int n = 0;
      while (START !== 1'b1 && n < 3000) begin @(negedge aclk); n++; end
      while (START !== 1'b0 && n < 3000) begin @(negedge aclk); n++; end
      ok = (n < 3000);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge aclk);
      checks++;
      if ({bus.spi_req_valid, bus.m_axis_tvalid, START, busy} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl: got %b want 0000", {bus.spi_req_valid, bus.m_axis_tvalid, START, busy});
      end
      checks++;
      if ({bus.spi_tx_len, bus.spi_tx_data} !== 35'h0) begin
         errors++; $display("FAIL reset_spi: got len=%0d data=%h want 0", bus.spi_tx_len, bus.spi_tx_data);
      end
      checks++;
      if (bus.m_axis_tdata !== 32'h0) begin
         errors++; $display("FAIL reset_tdata: got %h want 0", bus.m_axis_tdata);
      end
      checks++;
      if (timeout_cnt !== 16'h0) begin
         errors++; $display("FAIL reset_tmo_cnt: got %0d want 0", timeout_cnt);
      end
      aresetn = 1'b1;
   endtask

   task automatic test_scan();
      logic [31:0] w;
      bit          ok;
      logic [31:0] exp [4] = '{32'h00123456, 32'h20123456, 32'h00123456, 32'h20123456};
      logic [34:0] sexp[4] = '{{3'd3, 32'h40000100}, {3'd4, 32'h12FFFFFF},
                               {3'd3, 32'h40004500}, {3'd4, 32'h12FFFFFF}};
      words.delete(); spi_log.delete();
      cfg_run = 1'b1;
      for (int i = 0; i < 4; i++) begin
         get_word(w, ok);
         checks++;
         if (!ok || w !== exp[i]) begin
            errors++; $display("FAIL scan_word%0d: got %h ok=%0d want %h", i, w, ok, exp[i]);
         end
      end
      cfg_run = 1'b0;
      wait_busy_low();
      for (int i = 0; i < 4; i++) begin
         logic [34:0] s;
         s = (spi_log.size() > 0) ? spi_log.pop_front() : 35'h0;
         checks++;
         if (s !== sexp[i]) begin
            errors++; $display("FAIL scan_spi%0d: got len=%0d data=%h want len=%0d data=%h",
                               i, s[34:32], s[31:0], sexp[i][34:32], sexp[i][31:0]);
         end
      end
   endtask

   task automatic test_timeout();
      logic [31:0] w;
      bit          ok;
      logic [31:0] exp [3] = '{32'h00123456, 32'h28000000, 32'h00123456};
      words.delete(); spi_log.delete();
      blk_en = 1'b1; blk_mux = 8'h45;
      cfg_run = 1'b1;
      for (int i = 0; i < 3; i++) begin
         get_word(w, ok);
         checks++;
         if (!ok || w !== exp[i]) begin
            errors++; $display("FAIL timeout_word%0d: got %h ok=%0d want %h", i, w, ok, exp[i]);
         end
         if (i == 1) begin
            checks++;
            if (timeout_cnt !== 16'd1) begin
               errors++; $display("FAIL timeout_cnt: got %0d want 1", timeout_cnt);
            end
         end
      end
      cfg_run = 1'b0;
      wait_busy_low();
      blk_en = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] w;
      bit          ok;
      logic [34:0] s;
      int          n = 0;
      words.delete(); spi_log.delete();
      bus.m_axis_tready = 1'b0;
      cfg_run = 1'b1;
      while (bus.m_axis_tvalid !== 1'b1 && n < 3000) begin @(negedge aclk); n++; end
      for (int i = 0; i < 50; i++) begin
         @(negedge aclk);
         checks++;
         if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== 32'h20123456) begin
            errors++; $display("FAIL bp_hold%0d: got valid=%b data=%h want 1/20123456",
                               i, bus.m_axis_tvalid, bus.m_axis_tdata);
         end
         checks++;
         if (bus.spi_req_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_spi%0d: got req_valid=%b want 0", i, bus.spi_req_valid);
         end
      end
      checks++;
      if (spi_log.size() != 2) begin
         errors++; $display("FAIL bp_spi_count: got %0d want 2", spi_log.size());
      end
      bus.m_axis_tready = 1'b1;
      get_word(w, ok);
      checks++;
      if (!ok || w !== 32'h20123456) begin
         errors++; $display("FAIL bp_word0: got %h ok=%0d want 20123456", w, ok);
      end
      get_word(w, ok);
      cfg_run = 1'b0;
      checks++;
      if (!ok || w !== 32'h00123456) begin
         errors++; $display("FAIL bp_word1: got %h ok=%0d want 00123456", w, ok);
      end
      s = (spi_log.size() > 2) ? spi_log[2] : 35'h0;
      checks++;
      if (s !== {3'd3, 32'h40000100}) begin
         errors++; $display("FAIL bp_next_wreg: got len=%0d data=%h want 3/40000100", s[34:32], s[31:0]);
      end
      wait_busy_low();
   endtask

   task automatic test_pps();
      logic [31:0] w;
      bit          ok;
      logic [31:0] exp [3] = '{32'h20123456, 32'h04123456, 32'h20123456};
      words.delete(); spi_log.delete();
      cfg_chan_mask = 4'b1101;
      cfg_run = 1'b1;
      wait_start_pulse(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL pps_start_seen: got none want pulse"); end
      pps = 1'b1;
      repeat (3) @(negedge aclk);
      pps = 1'b0;
      for (int i = 0; i < 3; i++) begin
         get_word(w, ok);
         checks++;
         if (!ok || w !== exp[i]) begin
            errors++; $display("FAIL pps_word%0d: got %h ok=%0d want %h", i, w, ok, exp[i]);
         end
      end
      cfg_run = 1'b0;
      wait_busy_low();
      cfg_chan_mask = 4'b0101;
   endtask

   task automatic test_run_stop();
      logic [31:0] w;
      bit          ok;
      words.delete(); spi_log.delete();
      cfg_run = 1'b1;
      get_word(w, ok);
      checks++;
      if (!ok || w !== 32'h00123456) begin
         errors++; $display("FAIL stop_word0: got %h ok=%0d want 00123456", w, ok);
      end
      wait_start_pulse(ok);
      cfg_run = 1'b0;
      get_word(w, ok);
      checks++;
      if (!ok || w !== 32'h20123456) begin
         errors++; $display("FAIL stop_word1: got %h ok=%0d want 20123456", w, ok);
      end
      repeat (20) @(negedge aclk);
      checks++;
      if (busy !== 1'b0 || words.size() != 0) begin
         errors++; $display("FAIL stop_idle: got busy=%b extra_words=%0d want 0/0", busy, words.size());
      end
      cfg_run = 1'b1;
      get_word(w, ok);
      checks++;
      if (!ok || w !== 32'h00123456) begin
         errors++; $display("FAIL stop_resume: got %h ok=%0d want 00123456", w, ok);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      bit          ok;
      logic [31:0] exp [2] = '{32'h00123456, 32'h20123456};
      int          n = 0;
      while (START !== 1'b1 && n < 3000) begin @(negedge aclk); n++; end
      #1 aresetn = 1'b0;
      #1;
      checks++;
      if ({bus.spi_req_valid, bus.m_axis_tvalid, START, busy} !== 4'b0000) begin
         errors++; $display("FAIL rstmid_ctrl: got %b want 0000", {bus.spi_req_valid, bus.m_axis_tvalid, START, busy});
      end
      checks++;
      if ({bus.spi_tx_len, bus.spi_tx_data} !== 35'h0 || bus.m_axis_tdata !== 32'h0 || timeout_cnt !== 16'h0) begin
         errors++; $display("FAIL rstmid_data: got len=%0d tx=%h tdata=%h tmo=%0d want all 0",
                            bus.spi_tx_len, bus.spi_tx_data, bus.m_axis_tdata, timeout_cnt);
      end
      repeat (2) @(negedge aclk);
      words.delete(); spi_log.delete();
      aresetn = 1'b1;
      for (int i = 0; i < 2; i++) begin
         get_word(w, ok);
         checks++;
         if (!ok || w !== exp[i]) begin
            errors++; $display("FAIL rstmid_word%0d: got %h ok=%0d want %h", i, w, ok, exp[i]);
         end
      end
      cfg_run = 1'b0;
      wait_busy_low();
      checks++;
      if (spi_log.size() == 0 || spi_log[0] !== {3'd3, 32'h40000100}) begin
         errors++; $display("FAIL rstmid_first_wreg: got %h want 340000100",
                            (spi_log.size() > 0) ? spi_log[0] : 35'h0);
      end
   endtask

   initial begin
      bus.m_axis_tready = 1'b1;
      bus.spi_rx_data   = 24'h123456;
      blk_en  = 1'b0;
      blk_mux = 8'h00;
      test_reset();
      test_scan();
      test_timeout();
      test_backpressure();
      test_pps();
      test_run_stop();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
